// File: rtl/iob_axis2iob_wr_pkg.sv
// Common types for iob_axis2iob_wr: holding-register command encoding.
package iob_axis2iob_wr_pkg;

    typedef enum logic [1:0] {
        HOLD_KEEP  = 2'd0,
        HOLD_LOAD  = 2'd1,
        HOLD_CLEAR = 2'd2
    } hold_cmd_e;

endpackage

// File: rtl/iob_axis2iob_wr_conf.vh
// Shared FSM encodings and strobe width for iob_axis2iob_wr.
// Include inside a module body that already declares parameter DATA_W.
localparam logic [0:0] ST_IDLE = 1'b0;
localparam logic [0:0] ST_RUN  = 1'b1;
localparam int         STRB_W  = DATA_W / 8;

// File: rtl/iob_axis2iob_wr_hold.sv
// One-entry data/valid holding register between the stream side and the IOb side.
// LOAD wins over everything; CLEAR drops valid but leaves the data word in place.
module iob_axis2iob_wr_hold
    import iob_axis2iob_wr_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  hold_cmd_e         i_cmd,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            case (i_cmd)
                HOLD_LOAD: begin
                    r_valid <= 1'b1;
                    r_data  <= i_data;
                end
                HOLD_CLEAR: r_valid <= 1'b0;
                default: ;
            endcase
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/iob_axis2iob_wr.sv
// AXI-Stream to IOb write bridge: writes length_i words to consecutive addresses.
// Optional early end on tlast when IOB_AXIS2IOB_WR_TLAST_EN is defined.
module iob_axis2iob_wr
    import iob_axis2iob_wr_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                run_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [LEN_W-1:0]    length_i,
    output logic                ready_o,
    output logic                done_o,
    output logic [LEN_W-1:0]    count_o,
    input  logic [DATA_W-1:0]   axis_tdata_i,
    input  logic                axis_tvalid_i,
`ifdef IOB_AXIS2IOB_WR_TLAST_EN
    input  logic                axis_tlast_i,
`endif
    output logic                axis_tready_o,
    output logic                iob_valid_o,
    output logic [ADDR_W-1:0]   iob_addr_o,
    output logic [DATA_W-1:0]   iob_wdata_o,
    output logic [DATA_W/8-1:0] iob_wstrb_o,
    input  logic                iob_ready_i
);

    `include "iob_axis2iob_wr_conf.vh"

    logic [0:0]        r_state;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_rx_cnt;
    logic [LEN_W-1:0]  r_count;
    logic [ADDR_W-1:0] r_addr;
    logic              r_done;
    logic              r_last_seen;

    logic              w_run;
    logic              w_start;
    logic              w_beat;
    logic              w_wr;
    logic              w_last_wr;
    logic              w_hold_v;
    logic [LEN_W-1:0]  w_cnt_nxt;
    hold_cmd_e         w_cmd;

    assign w_run     = (r_state == ST_RUN);
    assign w_start   = ~w_run & run_i & (length_i != '0);
    assign w_wr      = w_hold_v & iob_ready_i;
    assign w_cnt_nxt = r_count + LEN_W'(1);

    // The holding slot frees up in the same cycle its word is accepted, giving 1 word/cycle.
    assign axis_tready_o = w_run & (r_rx_cnt != r_len) & ~r_last_seen & (~w_hold_v | iob_ready_i);
    assign w_beat        = axis_tvalid_i & axis_tready_o;

    // After tlast no more beats arrive, so the final write is the one that catches up with rx_cnt.
    assign w_last_wr = w_wr & ((w_cnt_nxt == r_len) | (r_last_seen & (w_cnt_nxt == r_rx_cnt)));

    always_comb begin
        w_cmd = HOLD_KEEP;
        if (w_beat)
            w_cmd = HOLD_LOAD;
        else if (w_wr)
            w_cmd = HOLD_CLEAR;
    end

    iob_axis2iob_wr_hold #(
        .DATA_W (DATA_W)
    ) u_hold (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_cmd   (w_cmd),
        .i_data  (axis_tdata_i),
        .o_valid (w_hold_v),
        .o_data  (iob_wdata_o)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= ST_IDLE;
            r_len    <= '0;
            r_rx_cnt <= '0;
            r_count  <= '0;
            r_addr   <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_start) begin
                r_state  <= ST_RUN;
                r_len    <= length_i;
                r_addr   <= addr_i;
                r_count  <= '0;
                r_rx_cnt <= '0;
            end else if (w_run) begin
                if (w_beat)
                    r_rx_cnt <= r_rx_cnt + LEN_W'(1);
                if (w_wr) begin
                    r_count <= w_cnt_nxt;
                    r_addr  <= r_addr + ADDR_W'(STRB_W);
                end
                if (w_last_wr) begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b1;
                end
            end
        end
    end

`ifdef IOB_AXIS2IOB_WR_TLAST_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            r_last_seen <= 1'b0;
        else if (w_start)
            r_last_seen <= 1'b0;
        else if (w_beat & axis_tlast_i)
            r_last_seen <= 1'b1;
    end
`else
    assign r_last_seen = 1'b0;
`endif

    assign ready_o     = ~w_run;
    assign done_o      = r_done;
    assign count_o     = r_count;
    assign iob_valid_o = w_hold_v;
    assign iob_addr_o  = r_addr;
    assign iob_wstrb_o = {STRB_W{w_hold_v}};

endmodule

// File: tb/tb_iob_axis2iob_wr.sv
// Directed bench for iob_axis2iob_wr: table of transfers plus reset/idle corner sequences.
// The tlast row is only exercised when IOB_AXIS2IOB_WR_TLAST_EN is defined.
module tb_iob_axis2iob_wr;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int LW = 16;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          run_i;
    logic [AW-1:0] addr_i;
    logic [LW-1:0] length_i;
    logic          ready_o;
    logic          done_o;
    logic [LW-1:0] count_o;
    logic [DW-1:0] axis_tdata_i;
    logic          axis_tvalid_i;
`ifdef IOB_AXIS2IOB_WR_TLAST_EN
    logic          axis_tlast_i;
`endif
    logic          axis_tready_o;
    logic          iob_valid_o;
    logic [AW-1:0] iob_addr_o;
    logic [DW-1:0] iob_wdata_o;
    logic [DW/8-1:0] iob_wstrb_o;
    logic          iob_ready_i;

    int errs   = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    iob_axis2iob_wr #(.DATA_W(DW), .ADDR_W(AW), .LEN_W(LW)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .run_i         (run_i),
        .addr_i        (addr_i),
        .length_i      (length_i),
        .ready_o       (ready_o),
        .done_o        (done_o),
        .count_o       (count_o),
        .axis_tdata_i  (axis_tdata_i),
        .axis_tvalid_i (axis_tvalid_i),
`ifdef IOB_AXIS2IOB_WR_TLAST_EN
        .axis_tlast_i  (axis_tlast_i),
`endif
        .axis_tready_o (axis_tready_o),
        .iob_valid_o   (iob_valid_o),
        .iob_addr_o    (iob_addr_o),
        .iob_wdata_o   (iob_wdata_o),
        .iob_wstrb_o   (iob_wstrb_o),
        .iob_ready_i   (iob_ready_i)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        string       nm;
        logic [31:0] a;
        int          len;
        int          stall_w;   // write index to stall (-1 none)
        int          stall_n;   // stall cycles
        int          tlast_at;  // beat number (1-based) carrying tlast, 0 none
        int          rerun;     // pulse run_i while running
        int          exp_n;     // expected words written
        int          exp_span;  // cycles from first write to done_o
    } vec_t;

    function automatic vec_t mk(input string nm, input logic [31:0] a, input int len,
                                input int sw, input int sn, input int tl, input int rr,
                                input int en, input int es);
        vec_t v;
        v.nm = nm; v.a = a; v.len = len; v.stall_w = sw; v.stall_n = sn;
        v.tlast_at = tl; v.rerun = rr; v.exp_n = en; v.exp_span = es;
        return v;
    endfunction

    task automatic xfer(input vec_t v);
        int beat = 0, wr = 0, stall_left = v.stall_n, cyc = 0, first = -1, done_cyc = -1;
        logic          pstall = 1'b0;
        logic          last_acc = 1'b0;
        logic [31:0]   pa = '0, pd = '0;
        logic [31:0]   ea;
        @(posedge clk_i); #1;
        run_i = 1'b1; addr_i = v.a; length_i = LW'(v.len);
        @(posedge clk_i); #1;
        run_i = 1'b0;
        chk({v.nm, "_ready_low"}, ready_o, 1'b0);
        while (done_cyc < 0 && cyc < 200) begin
            if (v.rerun != 0 && cyc == 0) begin
                run_i = 1'b1; addr_i = 32'hDEAD_0000; length_i = 16'd9;
            end else begin
                run_i = 1'b0;
            end
            axis_tvalid_i = 1'b1;
            axis_tdata_i  = 32'hA500_0000 + 32'(beat);
`ifdef IOB_AXIS2IOB_WR_TLAST_EN
            axis_tlast_i  = (beat == v.tlast_at - 1);
`endif
            iob_ready_i   = !(wr == v.stall_w && stall_left > 0);
            #1;
            if (done_o) done_cyc = cyc;
            if (pstall) begin
                chk({v.nm, "_hold_valid"}, iob_valid_o, 1'b1);
                chk({v.nm, "_hold_addr"}, iob_addr_o, pa);
                chk({v.nm, "_hold_data"}, iob_wdata_o, pd);
            end
            if (last_acc) chk({v.nm, "_tready_after_tlast"}, axis_tready_o, 1'b0);
            pstall = iob_valid_o && !iob_ready_i;
            pa = iob_addr_o; pd = iob_wdata_o;
            if (pstall) begin
                stall_left--;
                chk({v.nm, "_tready_stall"}, axis_tready_o, 1'b0);
            end
            if (iob_valid_o && iob_ready_i) begin
                ea = v.a + 32'(4 * wr);
                chk({v.nm, "_addr"}, iob_addr_o, ea);
                chk({v.nm, "_data"}, iob_wdata_o, 32'hA500_0000 + 32'(wr));
                chk({v.nm, "_wstrb"}, iob_wstrb_o, 4'hF);
                if (first < 0) first = cyc;
                wr++;
            end
            if (axis_tvalid_i && axis_tready_o) begin
                if (beat == v.tlast_at - 1) last_acc = 1'b1;
                beat++;
            end
            @(posedge clk_i); #1;
            cyc++;
        end
        axis_tvalid_i = 1'b0;
        run_i = 1'b0;
        chk({v.nm, "_done_seen"}, (done_cyc >= 0), 1'b1);
        chk({v.nm, "_writes"}, wr, v.exp_n);
        chk({v.nm, "_beats"}, beat, v.exp_n);
        chk({v.nm, "_span"}, done_cyc - first, v.exp_span);
        chk({v.nm, "_count"}, count_o, v.exp_n);
        // the cycle after done: pulse gone, count held, idle
        chk({v.nm, "_done_pulse"}, done_o, 1'b0);
        chk({v.nm, "_ready_idle"}, ready_o, 1'b1);
        chk({v.nm, "_tready_idle"}, axis_tready_o, 1'b0);
        chk({v.nm, "_valid_idle"}, iob_valid_o, 1'b0);
        repeat (3) @(posedge clk_i);
        #1;
        chk({v.nm, "_count_hold"}, count_o, v.exp_n);
    endtask

    vec_t tbl[$];

    initial begin
        int wr;
        tbl.push_back(mk("basic4",  32'h0000_0100, 4, -1, 0, 0, 0, 4, 4));
        tbl.push_back(mk("stall3",  32'h0000_0200, 3,  1, 2, 0, 0, 3, 5));
        tbl.push_back(mk("wrap2",   32'hFFFF_FFFC, 2, -1, 0, 0, 0, 2, 2));
        tbl.push_back(mk("len1",    32'h0000_0040, 1, -1, 0, 0, 0, 1, 1));
        tbl.push_back(mk("rerun2",  32'h0000_0500, 2, -1, 0, 0, 1, 2, 2));
`ifdef IOB_AXIS2IOB_WR_TLAST_EN
        tbl.push_back(mk("tlast3",  32'h0000_0300, 8, -1, 0, 3, 0, 3, 3));
`endif

        rst_i = 1'b1; run_i = 1'b0; addr_i = '0; length_i = '0;
        axis_tdata_i = '0; axis_tvalid_i = 1'b0; iob_ready_i = 1'b1;
`ifdef IOB_AXIS2IOB_WR_TLAST_EN
        axis_tlast_i = 1'b0;
`endif
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_ready", ready_o, 1'b1);
        chk("rst_done", done_o, 1'b0);
        chk("rst_valid", iob_valid_o, 1'b0);
        chk("rst_wstrb", iob_wstrb_o, 4'h0);
        chk("rst_addr", iob_addr_o, 32'h0);
        chk("rst_wdata", iob_wdata_o, 32'h0);
        chk("rst_count", count_o, 16'h0);
        chk("rst_tready", axis_tready_o, 1'b0);
        rst_i = 1'b0;

        foreach (tbl[i]) xfer(tbl[i]);

        // zero-length start is ignored
        @(posedge clk_i); #1;
        run_i = 1'b1; addr_i = 32'h0000_0900; length_i = '0; axis_tvalid_i = 1'b1;
        @(posedge clk_i); #1;
        run_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk("len0_ready", ready_o, 1'b1);
            chk("len0_valid", iob_valid_o, 1'b0);
            chk("len0_done", done_o, 1'b0);
            chk("len0_tready", axis_tready_o, 1'b0);
            @(posedge clk_i); #1;
        end
        axis_tvalid_i = 1'b0;

        // reset after two of eight words
        run_i = 1'b1; addr_i = 32'h0000_0800; length_i = 16'd8;
        @(posedge clk_i); #1;
        run_i = 1'b0; axis_tvalid_i = 1'b1; axis_tdata_i = 32'h5A5A_0000; iob_ready_i = 1'b1;
        wr = 0;
        for (int c = 0; c < 20 && wr < 2; c++) begin
            if (iob_valid_o && iob_ready_i) wr++;
            @(posedge clk_i); #1;
        end
        chk("abort_pre_count", count_o, 16'd2);
        rst_i = 1'b1;
        #1;
        chk("abort_ready", ready_o, 1'b1);
        chk("abort_done", done_o, 1'b0);
        chk("abort_valid", iob_valid_o, 1'b0);
        chk("abort_wstrb", iob_wstrb_o, 4'h0);
        chk("abort_addr", iob_addr_o, 32'h0);
        chk("abort_wdata", iob_wdata_o, 32'h0);
        chk("abort_count", count_o, 16'h0);
        chk("abort_tready", axis_tready_o, 1'b0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk_i); #1;
            chk("abort_no_done", done_o, 1'b0);
            chk("abort_no_valid", iob_valid_o, 1'b0);
        end
        axis_tvalid_i = 1'b0;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/iob_axis2iob_wr.md
IOB_AXIS2IOB_WR -- requirements
Module: iob_axis2iob_wr

Interface
REQ-001 SHALL have parameter DATA_W, default 32, stream and IOb data width in bits (multiple of 8).
REQ-002 SHALL have parameter ADDR_W, default 32, IOb byte-address width.
REQ-003 SHALL have parameter LEN_W, default 16, width of transfer length in words.
REQ-004 SHALL have port clk_i  input  1  clock; all state on rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port run_i  input  1  start pulse; sampled in IDLE only.
REQ-007 SHALL have port addr_i  input  ADDR_W  first byte address, word-aligned.
REQ-008 SHALL have port length_i  input  LEN_W  words to transfer.
REQ-009 SHALL have port ready_o  output  1  high in IDLE.
REQ-010 SHALL have port done_o  output  1  one-cycle pulse at transfer end.
REQ-011 SHALL have port count_o  output  LEN_W  words written in current/last transfer.
REQ-012 SHALL have ports axis_tdata_i  input  DATA_W; axis_tvalid_i  input  1; axis_tready_o  output  1 (AXI-Stream subordinate).
REQ-013 SHALL have ports iob_valid_o  output  1; iob_addr_o  output  ADDR_W; iob_wdata_o  output  DATA_W; iob_wstrb_o  output  DATA_W/8; iob_ready_i  input  1 (IOb manager, write-only).

Function
REQ-014 SHALL implement states IDLE, RUN; IDLE->RUN when run_i=1 and length_i!=0; run_i with length_i=0 SHALL be ignored (no done_o).
REQ-015 On IDLE->RUN SHALL latch addr_i, length_i; clear count_o and rx counter.
REQ-016 run_i in RUN SHALL be ignored.
REQ-017 axis_tready_o SHALL be combinational: RUN & (rx_cnt!=length) & (~iob_valid_o | iob_ready_i).
REQ-018 Stream beat accepted when axis_tvalid_i & axis_tready_o; data SHALL load a holding register; iob_valid_o SHALL rise next cycle (1-cycle latency).
REQ-019 iob_valid_o, iob_addr_o, iob_wdata_o SHALL stay stable until iob_valid_o & iob_ready_i in same cycle.
REQ-020 iob_wstrb_o SHALL be all ones when iob_valid_o=1, zero otherwise.
REQ-021 Accepted IOb write SHALL increment count_o by 1 and iob_addr_o by DATA_W/8 (modulo 2^ADDR_W, wrap silent).
REQ-022 Write-accept and new beat in same cycle SHALL give back-to-back valid (throughput 1 word/cycle).
REQ-023 When count_o reaches latched length SHALL go RUN->IDLE and pulse done_o same edge; ready_o high next cycle.
REQ-024 count_o SHALL hold its final value in IDLE until next accepted run_i.

Reset
REQ-025 rst_i SHALL force: state IDLE, ready_o=1, done_o=0, iob_valid_o=0, iob_wstrb_o=0, iob_addr_o=0, iob_wdata_o=0, count_o=0, axis_tready_o=0.
REQ-026 rst_i mid-transfer SHALL abort immediately; held word discarded; no done_o.

Configuration
REQ-027 Macro IOB_AXIS2IOB_WR_TLAST_EN defined: SHALL add port axis_tlast_i input 1; accepted beat with tlast=1 SHALL stop further tready and end transfer (done_o) after that word's IOb write, count_o giving words written.
REQ-028 Macro undefined: no axis_tlast_i port; transfer ends only on length (REQ-023).

Structure
REQ-029 State encodings and localparam STRB_W=DATA_W/8 SHALL live in shared header iob_axis2iob_wr_conf.vh.
REQ-030 One sub-module SHALL be natural: iob_axis2iob_wr_hold (one-entry data/valid holding register with load/clear).

Verification
REQ-031 Reset, run_i addr=0x100 len=4, tvalid always 1, iob_ready_i always 1 -> writes at 0x100,0x104,0x108,0x10C on 4 consecutive cycles, done_o at 4th, count_o=4.
REQ-032 len=3, iob_ready_i low 2 cycles on 2nd word -> address/data held stable, tready low during stall, no beat lost, count_o=3.
REQ-033 run_i len=0 -> stays IDLE, no iob_valid_o, no done_o; run_i during RUN -> ignored.
REQ-034 addr=0xFFFFFFFC len=2 -> writes at 0xFFFFFFFC then 0x00000000.
REQ-035 rst_i asserted after 2 of 8 words -> all outputs at reset values same cycle, ready_o=1.
REQ-036 With IOB_AXIS2IOB_WR_TLAST_EN, len=8, tlast on beat 3 -> 3 writes, done_o, count_o=3, tready low thereafter.
